wavetable_reader: RTL and testbench

Read-side client of the synth's 61-entry wavetable RAM. Each entry holds left waveform, right waveform and a crossfade factor.
- Accepts an index request and issues the registered RAM read.
- Crossfades the two 8-bit samples by the stored factor.
- Presents one 8-bit mixed sample on a valid/ready handshake to the voice/output stage.

---
 rtl/wavetable_reader.sv | 154 +++++++++++++++
 tb/tb_wavetable_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_reader.sv
// Wavetable read client: fetches one entry, crossfades left/right by factor, hands out a sample.
// Optional macro WAVETABLE_READER_SCAN_EN adds a scan input that self-issues sequential fetches.
module wavetable_reader #(
    parameter int unsigned TABLE_SIZE = 61,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_index,
    output logic              req_ready,
    input  logic              ram_busy,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_left,
    input  logic [DATA_W-1:0] ram_right,
    input  logic [DATA_W-1:0] ram_factor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sample,
`ifdef WAVETABLE_READER_SCAN_EN
    input  logic              scan,
`endif
    output logic              out_err
);

    localparam int unsigned PW = 2 * DATA_W + 1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(TABLE_SIZE - 1);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StMix, StOut} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic [DATA_W-1:0] factor_q, factor_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              out_err_q, out_err_d;
`ifdef WAVETABLE_READER_SCAN_EN
    logic [ADDR_W-1:0] ptr_q, ptr_d;
`endif

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    logic [DATA_W-1:0]      mix;

    // Result is always in range, so modulo-2^DATA_W addition of the shifted term is exact.
    assign diff = $signed({1'b0, right_q}) - $signed({1'b0, left_q});
    assign prod = PW'(diff) * PW'($signed({1'b0, factor_q}));
    assign mix  = left_q + DATA_W'(prod >>> DATA_W);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        left_d    = left_q;
        right_d   = right_q;
        factor_d  = factor_q;
        sample_d  = sample_q;
        out_err_d = out_err_q;
`ifdef WAVETABLE_READER_SCAN_EN
        ptr_d     = ptr_q;
`endif
        req_ready = 1'b0;
        ram_re    = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (32'(req_index) >= TABLE_SIZE) begin
                        idx_d = LastIdx;
                        err_d = 1'b1;
                    end else begin
                        idx_d = req_index;
                        err_d = 1'b0;
                    end
                    state_d = StRead;
                end
`ifdef WAVETABLE_READER_SCAN_EN
                else if (scan) begin
                    idx_d   = ptr_q;
                    err_d   = 1'b0;
                    ptr_d   = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;
                    state_d = StRead;
                end
`endif
            end
            StRead: begin
                ram_re = 1'b1;
                // A RAM write in the same cycle drops our read; retry until it goes through.
                if (!ram_busy) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                left_d   = ram_left;
                right_d  = ram_right;
                factor_d = ram_factor;
                state_d  = StMix;
            end
            StMix: begin
                sample_d  = mix;
                out_err_d = err_q;
                state_d   = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            err_q     <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            factor_q  <= '0;
            sample_q  <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            left_q    <= left_d;
            right_q   <= right_d;
            factor_q  <= factor_d;
            sample_q  <= sample_d;
            out_err_q <= out_err_d;
        end
    end

`ifdef WAVETABLE_READER_SCAN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign ram_addr   = idx_q;
    assign out_valid  = (state_q == StOut);
    assign out_sample = sample_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: directed vector table, corner sequences, random traffic.
module tb_wavetable_reader;

    localparam int TS = 61;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [5:0] req_index;
    logic       req_ready;
    logic       ram_busy;
    logic       ram_re;
    logic [5:0] ram_addr;
    logic [7:0] ram_left, ram_right, ram_factor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sample;
    logic       out_err;
`ifdef WAVETABLE_READER_SCAN_EN
    logic       scan = 1'b0;
`endif

    wavetable_reader dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_ready  (req_ready),
        .ram_busy   (ram_busy),
        .ram_re     (ram_re),
        .ram_addr   (ram_addr),
        .ram_left   (ram_left),
        .ram_right  (ram_right),
        .ram_factor (ram_factor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
`ifdef WAVETABLE_READER_SCAN_EN
        .scan       (scan),
`endif
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model; a busy (write) cycle drops the read.
    logic [7:0] mem_l [64];
    logic [7:0] mem_r [64];
    logic [7:0] mem_f [64];
    always @(posedge clk) begin
        if (ram_re && !ram_busy) begin
            ram_left   <= mem_l[ram_addr];
            ram_right  <= mem_r[ram_addr];
            ram_factor <= mem_f[ram_addr];
        end
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int clamp_idx(input int i);
        return (i >= TS) ? TS - 1 : i;
    endfunction

    // left + floor((right - left) * factor / 256)
    function automatic int mix_ref(input int l, input int r, input int f);
        int p, q;
        p = (r - l) * f;
        if (p >= 0) q = p / 256;
        else q = -((-p + 255) / 256);
        return l + q;
    endfunction

    task automatic load(input int idx, input int l, input int r, input int f);
        int a;
        a = clamp_idx(idx);
        mem_l[a] = 8'(l);
        mem_r[a] = 8'(r);
        mem_f[a] = 8'(f);
    endtask

    task automatic run_txn(input string tag, input int idx, input int busy, input int hold,
                           input int exp_s, input int exp_e, input int exp_lat);
        int a, lat, busy_left;
        a = clamp_idx(idx);
        busy_left = busy;
        @(negedge clk);
        check({tag, ".req_ready"}, int'(req_ready), 1);
        req_valid = 1'b1;
        req_index = 6'(idx);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_index = 6'($urandom);
        lat = 1;
        check({tag, ".ram_re"}, int'(ram_re), 1);
        check({tag, ".ram_addr"}, int'(ram_addr), a);
        while (!out_valid && lat < 40) begin
            if (ram_re && busy_left > 0) begin
                ram_busy = 1'b1;
                busy_left--;
                check({tag, ".stall_addr"}, int'(ram_addr), a);
            end else begin
                ram_busy = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        ram_busy = 1'b0;
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".sample"}, int'(out_sample), exp_s);
        check({tag, ".err"}, int'(out_err), exp_e);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            req_valid = 1'b1;
            @(negedge clk);
            check({tag, ".hold_valid"}, int'(out_valid), 1);
            check({tag, ".hold_sample"}, int'(out_sample), exp_s);
            check({tag, ".hold_err"}, int'(out_err), exp_e);
            check({tag, ".hold_ready"}, int'(req_ready), 0);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".drain_valid"}, int'(out_valid), 0);
        check({tag, ".drain_ready"}, int'(req_ready), 1);
        out_ready = 1'b0;
    endtask

    typedef struct {
        int idx, l, r, f, busy, hold, exp_s, exp_e, exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, r, f, idx, busy, hold;
        int rises[$];
        int cyc;

        vecs[0] = '{idx: 5,  l: 100, r: 200, f: 128, busy: 0, hold: 0, exp_s: 150, exp_e: 0, exp_lat: 4};
        vecs[1] = '{idx: 7,  l: 0,   r: 255, f: 0,   busy: 0, hold: 0, exp_s: 0,   exp_e: 0, exp_lat: 4};
        vecs[2] = '{idx: 8,  l: 0,   r: 255, f: 255, busy: 0, hold: 0, exp_s: 254, exp_e: 0, exp_lat: 4};
        vecs[3] = '{idx: 9,  l: 255, r: 0,   f: 255, busy: 0, hold: 0, exp_s: 0,   exp_e: 0, exp_lat: 4};
        vecs[4] = '{idx: 11, l: 250, r: 10,  f: 64,  busy: 0, hold: 0, exp_s: 190, exp_e: 0, exp_lat: 4};
        vecs[5] = '{idx: 12, l: 100, r: 200, f: 128, busy: 3, hold: 0, exp_s: 150, exp_e: 0, exp_lat: 7};
        vecs[6] = '{idx: 63, l: 40,  r: 80,  f: 128, busy: 0, hold: 5, exp_s: 60,  exp_e: 1, exp_lat: 4};
        vecs[7] = '{idx: 60, l: 1,   r: 3,   f: 255, busy: 0, hold: 1, exp_s: 2,   exp_e: 0, exp_lat: 4};
        vecs[8] = '{idx: 61, l: 200, r: 100, f: 1,   busy: 1, hold: 0, exp_s: 199, exp_e: 1, exp_lat: 5};

        for (int i = 0; i < 64; i++) begin
            mem_l[i] = 8'($urandom);
            mem_r[i] = 8'($urandom);
            mem_f[i] = 8'($urandom);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        ram_busy = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.req_ready", int'(req_ready), 1);
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.out_sample", int'(out_sample), 0);
        check("reset.out_err", int'(out_err), 0);
        check("reset.ram_re", int'(ram_re), 0);
        check("reset.ram_addr", int'(ram_addr), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            load(vecs[i].idx, vecs[i].l, vecs[i].r, vecs[i].f);
            run_txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].busy, vecs[i].hold,
                    vecs[i].exp_s, vecs[i].exp_e, vecs[i].exp_lat);
        end

        // Reset asserted while a read is in flight.
        load(3, 10, 20, 30);
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 6'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midreset.in_read", int'(ram_re), 1);
        #1 rst = 1'b1;
        #1;
        check("midreset.out_valid", int'(out_valid), 0);
        check("midreset.req_ready", int'(req_ready), 1);
        check("midreset.ram_re", int'(ram_re), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midreset.quiet_ram_re", int'(ram_re), 0);
            check("midreset.quiet_valid", int'(out_valid), 0);
        end

        // Back-to-back: request and out_ready held high, one sample every 5 cycles.
        load(5, 100, 200, 128);
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 6'd5;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (out_valid) rises.push_back(cyc);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        check("b2b.count", rises.size(), 5);
        if (rises.size() >= 3) begin
            check("b2b.gap0", rises[1] - rises[0], 5);
            check("b2b.gap1", rises[2] - rises[1], 5);
        end

        // Random traffic against the arithmetic model.
        for (int t = 0; t < 30; t++) begin
            idx  = int'($urandom_range(0, 63));
            l    = int'($urandom_range(0, 255));
            r    = int'($urandom_range(0, 255));
            f    = int'($urandom_range(0, 255));
            busy = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 2));
            load(idx, l, r, f);
            run_txn($sformatf("rnd%0d", t), idx, busy, hold, mix_ref(l, r, f),
                    (idx >= TS) ? 1 : 0, 4 + busy);
        end

`ifdef WAVETABLE_READER_SCAN_EN
        begin
            int exp_addr[$];
            int got_addr[$];
            int errs;
            bit injected;
            for (int i = 0; i < 20; i++) exp_addr.push_back(i);
            exp_addr.push_back(10);
            for (int i = 20; i < TS; i++) exp_addr.push_back(i);
            exp_addr.push_back(0);
            errs = 0;
            injected = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            scan = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < 800 && got_addr.size() < exp_addr.size(); k++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (ram_re) got_addr.push_back(int'(ram_addr));
                if (out_valid && out_err) errs++;
                if (!injected && got_addr.size() == 20 && req_ready) begin
                    req_valid = 1'b1;
                    req_index = 6'd10;
                    injected = 1'b1;
                end
            end
            scan = 1'b0;
            req_valid = 1'b0;
            repeat (8) @(negedge clk);
            out_ready = 1'b0;
            check("scan.count", got_addr.size(), exp_addr.size());
            check("scan.err", errs, 0);
            for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
                check($sformatf("scan.addr%0d", i), got_addr[i], exp_addr[i]);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
